// File: rtl/ddr_out_serialiser.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ddr_out_serialiser: multi-lane parallel-to-serial DDR pad transmitter.    |
// | Define DDR_SER_OE_EN to add registered pad enables (oe).      Rev 1.0     |
// +---------------------------------------------------------------------------+
module ddr_out_serialiser #(
  parameter int W_LANES    = 4,
  parameter int BEATS      = 8,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [W_LANES*BEATS-1:0]   in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       busy,
  output logic [W_LANES-1:0]         q
`ifdef DDR_SER_OE_EN
  ,
  output logic [W_LANES-1:0]         oe
`endif
);

  localparam int              c_half     = BEATS / 2;
  localparam int              c_cw       = (c_half > 1) ? $clog2(c_half) : 1;
  localparam logic [c_cw-1:0] c_last     = c_cw'(c_half - 1);
  localparam logic [BEATS-1:0] c_ones     = '1;
  localparam logic [BEATS-1:0] c_fill_msb = ~(c_ones << 2);
  localparam logic [BEATS-1:0] c_fill_lsb = ~(c_ones >> 2);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_cw-1:0]   r_cnt, w_cnt_nxt;
  logic              w_last;
  logic              w_accept;
  logic              w_shift;

  assign w_last   = (r_cnt == c_last);
  assign in_ready = (r_state == S_IDLE) || w_last;
  assign w_accept = in_valid && in_ready;
  assign w_shift  = (r_state == S_SHIFT);
  assign busy     = w_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (!w_accept) w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + c_cw'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  for (genvar l = 0; l < W_LANES; l++) begin : g_lane
    logic [BEATS-1:0] r_sr;
    logic [BEATS-1:0] w_sr_adv;
    logic             w_head_rise, w_head_fall;
    logic             r_rise, r_fall;

    if (MSB_FIRST) begin : g_msb
      assign w_head_rise = r_sr[BEATS-1];
      assign w_head_fall = r_sr[BEATS-2];
      assign w_sr_adv    = (r_sr << 2) | (IDLE_LEVEL ? c_fill_msb : '0);
    end else begin : g_lsb
      assign w_head_rise = r_sr[0];
      assign w_head_fall = r_sr[1];
      assign w_sr_adv    = (r_sr >> 2) | (IDLE_LEVEL ? c_fill_lsb : '0);
    end

    // Both beats of a pair are captured on the same rising edge so the fall
    // beat is stable for the whole cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sr   <= {BEATS{IDLE_LEVEL}};
        r_rise <= IDLE_LEVEL;
        r_fall <= IDLE_LEVEL;
      end else begin
        if (w_accept)     r_sr <= in_data[l*BEATS +: BEATS];
        else if (w_shift) r_sr <= w_sr_adv;
        if (w_shift) begin
          r_rise <= w_head_rise;
          r_fall <= w_head_fall;
        end else begin
          r_rise <= IDLE_LEVEL;
          r_fall <= IDLE_LEVEL;
        end
      end
    end

    // Pad mux: rise beat while clk is high, fall beat while clk is low.
    assign q[l] = clk ? r_rise : r_fall;
  end

`ifdef DDR_SER_OE_EN
  logic [W_LANES-1:0] r_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_oe <= '0;
    else        r_oe <= {W_LANES{w_shift}};
  end

  assign oe = r_oe;
`endif

endmodule
`default_nettype wire
